// File: rtl/datapath_o.sv
// Execution datapath: 16-entry register file, an 8-op ALU, combinational status flags
// and a write-back counter, driven by the control word from control_o.
module datapath_o #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ctrl,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ld_en,
  input  logic [3:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] result,
  output logic             mayor,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_CMP  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [2:0] cnt_alu;
  logic [3:0] slc_mux_a;
  logic [3:0] slc_mux_b;
  logic [3:0] slc_reg;
  logic       w;

  assign {cnt_alu, slc_mux_a, slc_mux_b, slc_reg, w} = ctrl;

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] wr_count_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_we;

  // B selector code 15 is the external operand, not R15.
  assign op_a = regs_q[slc_mux_a];
  assign op_b = (slc_mux_b == 4'hF) ? ext_data : regs_q[slc_mux_b];

  always_comb begin
    alu_res = '0;
    case (cnt_alu)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_CMP:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SRL:  alu_res = op_a >> 1;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_we = w && (cnt_alu != OP_CMP);

  // The loader write is applied last so it overrides an ALU write to the same register.
  always_comb begin
    regs_d = regs_q;
    if (alu_we) regs_d[slc_reg] = alu_res;
    if (ld_en)  regs_d[ld_addr] = ld_data;
    wr_count_d = wr_count_q + CNT_W'(alu_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign result   = alu_res;
  assign zero     = (alu_res == '0);
  assign neg      = alu_res[WIDTH-1];
  assign mayor    = $signed(op_a) > $signed(op_b);
  assign dbg_data = regs_q[dbg_addr];
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_datapath_o.sv
// Directed bench for datapath_o: a table of ALU vectors plus hand-written write-back,
// collision, read-during-write, reset and counter-wrap sequences.
module tb_datapath_o;

  logic        clk;
  logic        rst;
  logic [15:0] ctrl;
  logic [15:0] ext_data;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] result;
  logic        mayor;
  logic        zero;
  logic        neg;
  logic [15:0] wr_count;

  logic [15:0] dbg_data_s;
  logic [15:0] result_s;
  logic        mayor_s;
  logic        zero_s;
  logic        neg_s;
  logic [3:0]  wr_count_s;

  datapath_o #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ext_data(ext_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .result(result),
    .mayor(mayor), .zero(zero), .neg(neg), .wr_count(wr_count)
  );

  // Second copy with a 4-bit counter, fed the same stimulus, to observe counter wrap.
  datapath_o #(.WIDTH(16), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ext_data(ext_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_s), .result(result_s),
    .mayor(mayor_s), .zero(zero_s), .neg(neg_s), .wr_count(wr_count_s)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] mk_ctrl(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] d,
                                          input logic wr);
    return {op, a, b, d, wr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic peek(input string name, input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] ext;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        m;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst = 1'b0; ctrl = '0; ext_data = '0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;

    // Test 1: preload, then reset with a write-back and a load pending in the same cycle.
    tick();
    for (int i = 1; i < 16; i++) load(4'(i), 16'(i) * 16'h1111);
    peek("preload_r15", 4'd15, 16'hFFFF);
    rst = 1'b1;
    ctrl = mk_ctrl(3'b000, 4'd1, 4'd2, 4'd3, 1'b1);
    ld_en = 1'b1; ld_addr = 4'd9; ld_data = 16'h5A5A;
    tick();
    rst = 1'b0; ctrl = '0; ld_en = 1'b0;
    for (int i = 0; i < 16; i++) peek($sformatf("reset_r%0d", i), 4'(i), 16'h0000);
    check("reset_wr_count", wr_count, 0);

    // ALU vectors: operands loaded, combinational outputs checked with w=0.
    vecs[0]  = '{3'b000, 4'd1, 4'd2,  16'd5,    16'd7,    16'h0000, 16'd12,   1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 4'd1, 4'd2,  16'd5,    16'd7,    16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b010, 4'd6, 4'd4,  16'd9,    16'd3,    16'h0000, 16'd6,    1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b011, 4'd1, 4'd2,  16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 4'd5, 4'd8,  16'h8001, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 4'd1, 4'd2,  16'h1234, 16'h4321, 16'h0000, 16'h5335, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 4'd10, 4'd11, 16'hFFFF, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b111, 4'd1, 4'd15, 16'd7,    16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{3'b000, 4'd1, 4'd15, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 4'd12, 4'd15, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b000, 4'd0, 4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b010, 4'd6, 4'd4,  16'd3,    16'd9,    16'h0000, 16'hFFFA, 1'b0, 1'b1, 1'b0};

    for (int v = 0; v < 12; v++) begin
      load(vecs[v].a_addr, vecs[v].a_val);
      if (vecs[v].b_addr != 4'hF) load(vecs[v].b_addr, vecs[v].b_val);
      ext_data = vecs[v].ext;
      ctrl = mk_ctrl(vecs[v].op, vecs[v].a_addr, vecs[v].b_addr, 4'd13, 1'b0);
      #1;
      check($sformatf("v%0d_result", v), result, vecs[v].res);
      check($sformatf("v%0d_zero", v),   zero,   vecs[v].z);
      check($sformatf("v%0d_neg", v),    neg,    vecs[v].n);
      check($sformatf("v%0d_mayor", v),  mayor,  vecs[v].m);
      tick();
      ctrl = '0;
    end
    check("vec_no_writes", wr_count, 0);
    peek("vec_r13_untouched", 4'd13, 16'h0000);

    // Test 2: ADD write-back, old value visible in the write cycle.
    load(4'd1, 16'd5);
    load(4'd2, 16'd7);
    ctrl = mk_ctrl(3'b000, 4'd1, 4'd2, 4'd4, 1'b1);
    #1;
    check("add_result", result, 16'd12);
    peek("add_r4_old", 4'd4, 16'd9);
    tick();
    ctrl = '0;
    peek("add_r4_new", 4'd4, 16'd12);
    check("add_wr_count", wr_count, 1);

    // Test 3: CMP sets flags but never writes, even with w=1.
    load(4'd6, 16'd3);
    load(4'd4, 16'd9);
    ctrl = mk_ctrl(3'b010, 4'd6, 4'd4, 4'd0, 1'b1);
    #1;
    check("cmp_neg", neg, 1'b1);
    check("cmp_zero", zero, 1'b0);
    check("cmp_mayor", mayor, 1'b0);
    tick();
    ctrl = '0;
    peek("cmp_r0_kept", 4'd0, 16'h0000);
    check("cmp_wr_count", wr_count, 1);

    // Test 4: wrap to zero with signed compare -1 > 1 false.
    load(4'd1, 16'hFFFF);
    ext_data = 16'h0001;
    ctrl = mk_ctrl(3'b000, 4'd1, 4'd15, 4'd1, 1'b1);
    #1;
    check("wrap_result", result, 16'h0000);
    check("wrap_zero", zero, 1'b1);
    check("wrap_mayor", mayor, 1'b0);
    tick();
    ctrl = '0;
    peek("wrap_r1", 4'd1, 16'h0000);
    check("wrap_wr_count", wr_count, 2);

    // Test 5: loader and ALU hit R4 together (loader wins), then different targets.
    ctrl = mk_ctrl(3'b000, 4'd1, 4'd2, 4'd4, 1'b1);
    ld_en = 1'b1; ld_addr = 4'd4; ld_data = 16'hAAAA;
    tick();
    ld_en = 1'b0; ctrl = '0;
    peek("coll_r4", 4'd4, 16'hAAAA);
    check("coll_wr_count", wr_count, 3);
    ctrl = mk_ctrl(3'b000, 4'd1, 4'd2, 4'd5, 1'b1);
    ld_en = 1'b1; ld_addr = 4'd6; ld_data = 16'h1234;
    tick();
    ld_en = 1'b0; ctrl = '0;
    peek("both_r5", 4'd5, 16'd7);
    peek("both_r6", 4'd6, 16'h1234);
    check("both_wr_count", wr_count, 4);

    // Same register as A, B and destination.
    load(4'd3, 16'h0011);
    ctrl = mk_ctrl(3'b000, 4'd3, 4'd3, 4'd3, 1'b1);
    tick();
    ctrl = '0;
    peek("self_add_r3", 4'd3, 16'h0022);

    // Test 6: SRL R5 <= R5 on consecutive cycles, no bypass.
    load(4'd5, 16'h8000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h2000);
    ctrl = mk_ctrl(3'b100, 4'd5, 4'd0, 4'd5, 1'b1);
    dbg_addr = 4'd5;
    #1;
    check("srl1_result", result, exp_q.pop_front());
    check("srl1_r5_old", dbg_data, 16'h8000);
    tick();
    check("srl2_result", result, exp_q.pop_front());
    check("srl2_r5_old", dbg_data, 16'h4000);
    tick();
    ctrl = '0;
    peek("srl_r5_final", 4'd5, 16'h2000);
    check("srl_wr_count", wr_count, 7);

    // Counter wrap on the 4-bit copy after 16 write-backs from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ext_data = 16'h00C3;
    ctrl = mk_ctrl(3'b111, 4'd0, 4'd15, 4'd7, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("cnt4_at_15", wr_count_s, 4'd15);
    tick();
    ctrl = '0;
    check("cnt4_wrapped", wr_count_s, 4'd0);
    check("cnt16_at_16", wr_count, 16);
    peek("pass_r7", 4'd7, 16'h00C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
